// File: rtl/rd_burst_sched.sv
// Read-burst scheduler: splits one read command into AXI3 AR bursts that are capped
// at MAX_BURST beats and never cross a 4 KB page. It also tracks bursts in flight via rlast.
module rd_burst_sched #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 4,
    parameter int MAX_BURST  = 16,
    parameter int BEAT_SHIFT = 3,
    parameter int CNT_W      = 16,
    parameter int MAX_OUTST  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_beats,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic              m_rready,
    input  logic              m_rlast,
    output logic              lenq_push,
    input  logic              lenq_full_n,
    output logic [3:0]        outst_cnt,
    output logic              done,
    output logic              err
);

    localparam int                BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [3:0]        OUTST_LIM = 4'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((1 << BEAT_SHIFT) - 1);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   rem;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_calc;
    logic [12:0]        b4k;
    logic               ar_fire;
    logic               r_fire;

    assign ar_fire   = m_arvalid && m_arready;
    assign r_fire    = m_rvalid && m_rready && m_rlast;
    assign lenq_push = ar_fire;

    // Beats left before the next 4 KB page; 4096 itself needs the 13th bit.
    assign b4k = (13'd4096 - {1'b0, addr[11:0]}) >> BEAT_SHIFT;

    always_comb begin
        burst_calc = BURST_W'(MAX_BURST);
        if (rem < CNT_W'(MAX_BURST)) burst_calc = BURST_W'(rem);
        if (b4k < 13'(burst_calc))   burst_calc = BURST_W'(b4k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            burst     <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arvalid <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr & ~LOW_MASK;
                        rem       <= cmd_beats;
                        cmd_ready <= 1'b0;
                        if (cmd_beats != '0) begin
                            state <= CALC;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    m_araddr <= addr;
                    m_arlen  <= LEN_W'(burst_calc - BURST_W'(1));
                    burst    <= burst_calc;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    // Throttling only gates the rise; a presented AR is never withdrawn.
                    if (!m_arvalid) begin
                        if (outst_cnt < OUTST_LIM && lenq_full_n) m_arvalid <= 1'b1;
                    end else if (m_arready) begin
                        m_arvalid <= 1'b0;
                        addr      <= addr + (ADDR_W'(burst) << BEAT_SHIFT);
                        rem       <= rem - CNT_W'(burst);
                        state     <= (rem == CNT_W'(burst)) ? DRAIN : CALC;
                    end
                end
                DRAIN: begin
                    if (outst_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A stray rlast with nothing in flight saturates the count and latches err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_cnt <= '0;
            err       <= 1'b0;
        end else if (ar_fire && !r_fire) begin
            outst_cnt <= outst_cnt + 4'd1;
        end else if (r_fire && !ar_fire) begin
            if (outst_cnt == '0) err <= 1'b1;
            else                 outst_cnt <= outst_cnt - 4'd1;
        end
    end

endmodule
